paula_uart_mon: RTL and testbench

PAULA_UART_MON -- requirements
Module: paula_uart_mon

---
 rtl/paula_uart_mon.sv | 217 +++++++++++++++++++++
 tb/tb_paula_uart_mon.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/paula_uart_mon.sv
// Passive monitor for the Paula serial transmit line: decodes 8/9-bit frames into a small FIFO.
// Optional break detection is enabled by defining PAULA_UART_MON_BRK_EN.
module paula_uart_mon #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  clk7_en,
  input  logic                  reset,
  input  logic [15:0]           period_i,
  input  logic                  line_i,
  input  logic                  rd_i,
  input  logic                  ovr_clr_i,
  output logic [9:0]            data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  ovr_o,
  output logic                  brk_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ZERO = (DEPTH_LOG2 + 1)'(0);
  localparam logic [DEPTH_LOG2:0] PTR_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0] DEPTH_L  = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic [1:0]            sync_r;
  logic                  line_prev_r;
  state_t                state_r, state_nx;
  logic [15:0]           cnt_r, cnt_nx;
  logic [15:0]           tm1_r, tm1_nx;
  logic                  long_r, long_nx;
  logic [3:0]            bit_r, bit_nx;
  logic [8:0]            shift_r, shift_nx;
  logic                  line_s, fall_s;
  logic [3:0]            last_s;
  logic                  push_s;
  logic [9:0]            push_data_s;
  logic [9:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr_r, rd_ptr_r;
  logic                  pop_s, wr_en_s, ovr_set_s, ovr_r;
`ifdef PAULA_UART_MON_BRK_EN
  logic                  brk_set_s;
  logic                  brk_r;
`endif

  assign line_s = sync_r[1];
  assign fall_s = line_prev_r & ~line_s;
  assign last_s = long_r ? 4'd8 : 4'd7;
  assign ovr_o  = ovr_r;

  // Frame decoder next-state logic; T-1 is kept instead of T so a maximum period still fits 16 bits.
  always_comb begin
    state_nx    = state_r;
    cnt_nx      = cnt_r;
    tm1_nx      = tm1_r;
    long_nx     = long_r;
    bit_nx      = bit_r;
    shift_nx    = shift_r;
    push_s      = 1'b0;
    push_data_s = {~line_s, shift_r};
`ifdef PAULA_UART_MON_BRK_EN
    brk_set_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (fall_s) begin
          state_nx = ST_START;
          cnt_nx   = {1'b0, period_i[14:0]};
          tm1_nx   = {period_i[14:0], 1'b1};
          long_nx  = period_i[15];
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == 16'h0000) begin
          if (!line_s) begin
            state_nx = ST_DATA;
            cnt_nx   = tm1_r;
            bit_nx   = 4'h0;
            shift_nx = 9'h000;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          cnt_nx = cnt_r - 16'h0001;
        end
      end
      ST_DATA: begin
        if (cnt_r == 16'h0000) begin
          shift_nx[bit_r] = line_s;
          cnt_nx          = tm1_r;
          if (bit_r == last_s) begin
            state_nx = ST_STOP;
          end else begin
            bit_nx = bit_r + 4'h1;
          end
        end else begin
          cnt_nx = cnt_r - 16'h0001;
        end
      end
      ST_STOP: begin
        if (cnt_r == 16'h0000) begin
          state_nx = ST_IDLE;
`ifdef PAULA_UART_MON_BRK_EN
          if ((shift_r == 9'h000) && !line_s) begin
            brk_set_s = 1'b1;
          end else begin
            push_s = 1'b1;
          end
`else
          push_s = 1'b1;
`endif
        end else begin
          cnt_nx = cnt_r - 16'h0001;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Synchroniser and decoder state registers.
  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        sync_r      <= 2'b11;
        line_prev_r <= 1'b1;
        state_r     <= ST_IDLE;
        cnt_r       <= 16'h0000;
        tm1_r       <= 16'h0000;
        long_r      <= 1'b0;
        bit_r       <= 4'h0;
        shift_r     <= 9'h000;
      end else begin
        sync_r      <= {sync_r[0], line_i};
        line_prev_r <= sync_r[1];
        state_r     <= state_nx;
        cnt_r       <= cnt_nx;
        tm1_r       <= tm1_nx;
        long_r      <= long_nx;
        bit_r       <= bit_nx;
        shift_r     <= shift_nx;
      end
    end
  end

  // FIFO status and head; a pop frees the slot that a same-tick push needs when full.
  always_comb begin
    level_o = wr_ptr_r - rd_ptr_r;
    empty_o = (level_o == PTR_ZERO);
    full_o  = (level_o == DEPTH_L);
    if (empty_o) begin
      data_o = 10'h000;
    end else begin
      data_o = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
    end
    pop_s     = rd_i & ~empty_o;
    wr_en_s   = push_s & (~full_o | pop_s);
    ovr_set_s = push_s & full_o & ~pop_s;
  end

  // FIFO pointers and sticky overflow; a set wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        wr_ptr_r <= PTR_ZERO;
        rd_ptr_r <= PTR_ZERO;
        ovr_r    <= 1'b0;
      end else begin
        if (wr_en_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
        if (ovr_set_s) begin
          ovr_r <= 1'b1;
        end else if (ovr_clr_i) begin
          ovr_r <= 1'b0;
        end
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (clk7_en && !reset && wr_en_s) begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= push_data_s;
    end
  end

`ifdef PAULA_UART_MON_BRK_EN
  // Break flag holds until the synchronised line returns high.
  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        brk_r <= 1'b0;
      end else if (brk_set_s) begin
        brk_r <= 1'b1;
      end else if (line_s) begin
        brk_r <= 1'b0;
      end
    end
  end
  assign brk_o = brk_r;
`else
  assign brk_o = 1'b0;
`endif

endmodule

// File: tb/tb_paula_uart_mon.sv
// Self-checking bench for paula_uart_mon: a tick-level queue model of the FIFO fed by
// frames whose decode instant is derived from the bit timing, plus randomized traffic.
module tb_paula_uart_mon;
  localparam int DEPTH = 8;
`ifdef PAULA_UART_MON_BRK_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clk7_en = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] period_i = 16'h0002;
  logic        line_i = 1'b1;
  logic        rd_i = 1'b0;
  logic        ovr_clr_i = 1'b0;
  logic [9:0]  data_o;
  logic        empty_o, full_o, ovr_o, brk_o;
  logic [3:0]  level_o;

  paula_uart_mon #(.DEPTH_LOG2(3)) dut (
    .clk(clk), .clk7_en(clk7_en), .reset(reset), .period_i(period_i),
    .line_i(line_i), .rd_i(rd_i), .ovr_clr_i(ovr_clr_i), .data_o(data_o),
    .empty_o(empty_o), .full_o(full_o), .level_o(level_o), .ovr_o(ovr_o), .brk_o(brk_o)
  );

  always #5 clk = ~clk;

  int         n_total = 0;
  int         n_bad = 0;
  logic [9:0] q[$];
  logic       ovr_m = 1'b0;
  logic       brk_m = 1'b0;
  int         tick_no = 0;
  int         pend_tick = -1;
  logic [9:0] pend_data = 10'h000;
  int         rd_at_tick = -1;
  int         clr_at_tick = -1;
  bit         man_rd = 1'b0;
  bit         man_clr = 1'b0;
  bit         rand_io = 1'b0;
  logic       hist1 = 1'b1;
  logic       hist2 = 1'b1;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (tick %0d)", tag, obs, exp, tick_no);
    end
  endtask

  // One clk7_en tick: optional disabled gap, reference update, edge, output compare.
  task automatic tick();
    logic       pop_ok, do_push, ovf, brk_set;
    logic [9:0] head;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
    rd_i      = man_rd || (tick_no == rd_at_tick) || (rand_io && $urandom_range(0, 5) == 0);
    ovr_clr_i = man_clr || (tick_no == clr_at_tick) || (rand_io && $urandom_range(0, 30) == 0);
    clk7_en   = 1'b1;
    if (reset) begin
      q.delete();
      ovr_m = 1'b0;
      brk_m = 1'b0;
      pend_tick = -1;
      hist1 = 1'b1;
      hist2 = 1'b1;
    end else begin
      pop_ok  = rd_i && (q.size() > 0);
      do_push = 1'b0;
      ovf     = 1'b0;
      brk_set = 1'b0;
      if (tick_no == pend_tick) begin
        if (BRK_EN && pend_data == 10'h200) brk_set = 1'b1;
        else if (q.size() < DEPTH || pop_ok) do_push = 1'b1;
        else ovf = 1'b1;
      end
      if (brk_set) brk_m = 1'b1;
      else if (hist2) brk_m = 1'b0;
      if (pop_ok) void'(q.pop_front());
      if (do_push) q.push_back(pend_data);
      if (ovf) ovr_m = 1'b1;
      else if (ovr_clr_i) ovr_m = 1'b0;
      hist2 = hist1;
      hist1 = line_i;
    end
    @(posedge clk);
    #1;
    clk7_en   = 1'b0;
    rd_i      = 1'b0;
    ovr_clr_i = 1'b0;
    tick_no++;
    head = (q.size() > 0) ? q[0] : 10'h000;
    check_val("data_o", {6'h00, data_o}, {6'h00, head});
    check_val("empty_o", {15'h0, empty_o}, {15'h0, (q.size() == 0)});
    check_val("full_o", {15'h0, full_o}, {15'h0, (q.size() == DEPTH)});
    check_val("level_o", {12'h0, level_o}, 16'(q.size()));
    check_val("ovr_o", {15'h0, ovr_o}, {15'h0, ovr_m});
    check_val("brk_o", {15'h0, brk_o}, {15'h0, brk_m});
  endtask

  // Drive one frame; the stop bit is decoded T/2 into it after the two-stage synchroniser delay.
  task automatic send_frame(input logic [8:0] d, input logic long_f, input logic stop_b,
                            input logic [14:0] p, input int extra_low,
                            input bit rd_at_push, input bit clr_at_push);
    int t = 2 * (int'(p) + 1);
    int n = long_f ? 9 : 8;
    period_i  = {long_f, p};
    pend_tick = tick_no + t / 2 + (n + 1) * t + 2;
    pend_data = {~stop_b, (long_f ? d[8] : 1'b0), d[7:0]};
    rd_at_tick  = rd_at_push ? pend_tick : -1;
    clr_at_tick = clr_at_push ? pend_tick : -1;
    line_i = 1'b0;
    repeat (t) tick();
    for (int i = 0; i < n; i++) begin
      line_i = d[i];
      repeat (t) tick();
      if (i == 0) period_i = 16'($urandom);
    end
    line_i = stop_b;
    repeat (t) tick();
    if (extra_low > 0) begin
      line_i = 1'b0;
      repeat (extra_low) tick();
    end
    line_i = 1'b1;
    repeat (6) tick();
    rd_at_tick  = -1;
    clr_at_tick = -1;
  endtask

  task automatic drain();
    man_rd = 1'b1;
    repeat (DEPTH + 2) tick();
    man_rd = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check_val("rst.data", {6'h00, data_o}, 16'h0000);
    check_val("rst.empty", {15'h0, empty_o}, 16'h0001);
    check_val("rst.full", {15'h0, full_o}, 16'h0000);
    check_val("rst.level", {12'h0, level_o}, 16'h0000);
    check_val("rst.ovr", {15'h0, ovr_o}, 16'h0000);
    check_val("rst.brk", {15'h0, brk_o}, 16'h0000);
    reset = 1'b0;
    repeat (4) tick();

    send_frame(9'h055, 1'b0, 1'b1, 15'd2, 0, 1'b0, 1'b0);
    check_val("f55.data", {6'h00, data_o}, 16'h0055);
    check_val("f55.level", {12'h0, level_o}, 16'h0001);
    drain();
    send_frame(9'h1A5, 1'b1, 1'b1, 15'd2, 0, 1'b0, 1'b0);
    check_val("f1a5.data", {6'h00, data_o}, 16'h01A5);
    drain();
    send_frame(9'h03C, 1'b0, 1'b0, 15'd2, 0, 1'b0, 1'b0);
    check_val("ferr.data", {6'h00, data_o}, 16'h023C);
    drain();

    period_i = 16'h0002;
    line_i = 1'b0;
    repeat (2) tick();
    line_i = 1'b1;
    repeat (12) tick();
    check_val("glitch.empty", {15'h0, empty_o}, 16'h0001);

    for (int i = 1; i <= 9; i++) send_frame(9'(i), 1'b0, 1'b1, 15'd2, 0, 1'b0, 1'b0);
    check_val("ovf.full", {15'h0, full_o}, 16'h0001);
    check_val("ovf.ovr", {15'h0, ovr_o}, 16'h0001);
    for (int i = 1; i <= 8; i++) begin
      check_val("ovf.pop", {6'h00, data_o}, 16'(i));
      man_rd = 1'b1;
      tick();
      man_rd = 1'b0;
    end
    check_val("ovf.empty", {15'h0, empty_o}, 16'h0001);
    man_clr = 1'b1;
    tick();
    man_clr = 1'b0;
    check_val("ovf.clr", {15'h0, ovr_o}, 16'h0000);

    for (int i = 0; i < 8; i++) send_frame(9'(8'h40 + i), 1'b0, 1'b1, 15'd1, 0, 1'b0, 1'b0);
    send_frame(9'h0AA, 1'b0, 1'b1, 15'd1, 0, 1'b1, 1'b0);
    check_val("pp.level", {12'h0, level_o}, 16'h0008);
    check_val("pp.head", {6'h00, data_o}, 16'h0041);
    check_val("pp.ovr", {15'h0, ovr_o}, 16'h0000);
    send_frame(9'h0BB, 1'b0, 1'b1, 15'd1, 0, 1'b0, 1'b1);
    check_val("setclr.ovr", {15'h0, ovr_o}, 16'h0001);
    man_clr = 1'b1;
    tick();
    man_clr = 1'b0;
    drain();

    period_i = 16'h0002;
    line_i = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 4; i++) begin
      line_i = i[0];
      repeat (6) tick();
    end
    line_i = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (8) tick();
    check_val("rstmid.empty", {15'h0, empty_o}, 16'h0001);
    send_frame(9'h0A0, 1'b0, 1'b1, 15'd2, 0, 1'b0, 1'b0);
    check_val("rstmid.a0", {6'h00, data_o}, 16'h00A0);
    drain();

    send_frame(9'h000, 1'b0, 1'b0, 15'd2, 12, 1'b0, 1'b0);
    check_val("brk.level", {12'h0, level_o}, BRK_EN ? 16'h0000 : 16'h0001);
    check_val("brk.head", {6'h00, data_o}, BRK_EN ? 16'h0000 : 16'h0200);
    drain();

    rand_io = 1'b1;
    for (int i = 0; i < 24; i++) begin
      send_frame(9'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
                 15'($urandom_range(0, 5)), 0, 1'b0, 1'b0);
    end
    rand_io = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
